// File: rtl/instr_decode_stage_pkg.sv
// Shared definitions for the instruction decode stage:
// field positions, R-type opcode, occupancy encoding, decoder helper.
package instr_decode_stage_pkg;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int SH_HI  = 10;
    localparam int SH_LO  = 6;
    localparam int FN_HI  = 5;
    localparam int FN_LO  = 0;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;
    localparam int JA_HI  = 25;
    localparam int JA_LO  = 0;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] immediate;
        logic [25:0] jaddr;
        logic        is_rtype;
    } fields_t;

    function automatic fields_t decode(input logic [31:0] w);
        fields_t f;
        f.opcode    = w[OPC_HI:OPC_LO];
        f.rs        = w[RS_HI:RS_LO];
        f.rt        = w[RT_HI:RT_LO];
        f.rd        = w[RD_HI:RD_LO];
        f.shamt     = w[SH_HI:SH_LO];
        f.funct     = w[FN_HI:FN_LO];
        f.immediate = w[IMM_HI:IMM_LO];
        f.jaddr     = w[JA_HI:JA_LO];
        f.is_rtype  = (w[OPC_HI:OPC_LO] == OPC_RTYPE);
        return f;
    endfunction

endpackage

// File: rtl/instr_skid_buf.sv
// Two-entry in-order skid buffer with flush; payload is opaque.
// Head register always drives the output side.
module instr_skid_buf
    import instr_decode_stage_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    occ_e         state;
    occ_e         state_nx;
    logic [W-1:0] head_q;
    logic [W-1:0] tail_q;
    logic [W-1:0] head_nx;
    logic [W-1:0] tail_nx;
    logic         push;
    logic         pop;

    assign in_ready  = !rst && (state != TWO);
    assign out_valid = (state != EMPTY);
    assign out_data  = head_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            state  <= state_nx;
            head_q <= head_nx;
            tail_q <= tail_nx;
        end
    end

    // flush wins over any handshake in the same cycle
    always_comb begin
        state_nx = state;
        head_nx  = head_q;
        tail_nx  = tail_q;
        if (flush) begin
            state_nx = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (push) begin
                        state_nx = ONE;
                        head_nx  = in_data;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_nx = in_data;
                    end else if (push) begin
                        state_nx = TWO;
                        tail_nx  = in_data;
                    end else if (pop) begin
                        state_nx = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_nx = ONE;
                        head_nx  = tail_q;
                    end
                end
                default: state_nx = EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage: buffers fetched instructions and slices the head word
// into its fields; counts back-pressured cycles.
module instr_decode_stage
    import instr_decode_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [DATA_W-1:0] if_instr,
    input  logic [DATA_W-1:0] if_pc,
    input  logic              flush,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [DATA_W-1:0] id_pc,
    output logic [5:0]        opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [5:0]        funct,
    output logic [15:0]       immediate,
    output logic [25:0]       jaddr,
    output logic              is_rtype,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [2*DATA_W-1:0] head;
    fields_t             f;

    instr_skid_buf #(
        .W(2*DATA_W)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (if_valid),
        .in_ready (if_ready),
        .in_data  ({if_pc, if_instr}),
        .out_valid(id_valid),
        .out_ready(id_ready),
        .out_data (head)
    );

    // fields read as zero whenever nothing valid is held
    always_comb begin
        f     = '0;
        id_pc = '0;
        if (id_valid) begin
            f     = decode(head[31:0]);
            id_pc = head[2*DATA_W-1:DATA_W];
        end
    end

    assign opcode    = f.opcode;
    assign rs        = f.rs;
    assign rt        = f.rt;
    assign rd        = f.rd;
    assign shamt     = f.shamt;
    assign funct     = f.funct;
    assign immediate = f.immediate;
    assign jaddr     = f.jaddr;
    assign is_rtype  = f.is_rtype;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (id_valid && !id_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
